instr_mem_pipe: RTL and testbench
=================================

Name: instr_mem_pipe

Overview:
Parametrised successor to the IF-stage instruction memory. Holds DEPTH words of DATA_W bits behind a registered, pipelined read port with configurable latency, hold (stall) and error reporting. Adds a write port for program loading and a post-reset hardware init sweep that fills memory with a deterministic pattern. Sits between the PC register and the IF/ID pipeline register.

Parameters:
DATA_W, 32, word width in bits
DEPTH, 128, number of words; power of two, at least 2
ADDR_W, 32, width of rd_addr and wr_addr
BYTE_ADDR, 0, 0: addresses are word indices; 1: byte addresses, word index = addr >> 2, addr[1:0] must be 0
RD_LAT, 1, read latency in cycles; legal values 1 or 2
INIT_BASE, 0, init value of word 0
INIT_STEP, 1, increment between consecutive init words; word i = INIT_BASE + i*INIT_STEP, truncated to DATA_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
rd_req  in  1  read request
rd_addr  in  ADDR_W  read address
rd_hold  in  1  stall: freezes the read pipeline and outputs
rd_gnt  out  1  request accepted this cycle (combinational)
rd_valid  out  1  rd_data/rd_err are valid
rd_data  out  DATA_W  read data
rd_err  out  1  response is for an out-of-range or misaligned address
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address (same addressing mode as reads)
wr_data  in  DATA_W  write data
wr_err  out  1  one-cycle pulse: previous-cycle write was dropped
busy  out  1  init sweep in progress
init_done  out  1  high once the sweep completes, until next reset

Behaviour:
- Reset values: rd_valid 0, rd_data 0, rd_err 0, wr_err 0, busy 1, init_done 0. Pipeline stages cleared. Init counter 0. Memory array is not cleared by reset.
- FSM states: INIT and RUN. rst forces INIT from any state.
- INIT: one word per cycle. Word cnt = INIT_BASE + cnt*INIT_STEP. Runs DEPTH cycles, cnt 0..DEPTH-1. After writing word DEPTH-1, go to RUN: busy 0, init_done 1 from the next cycle. In INIT, rd_gnt = 0 and wr_en is ignored (no wr_err).
- RUN: rd_gnt = rd_req & ~rd_hold.
- Accepted read at cycle T: response appears with rd_valid = 1 at T+RD_LAT, counting only non-hold cycles. Back-to-back reads give one response per cycle.
- Index decode:
  - BYTE_ADDR=0: idx = addr.
  - BYTE_ADDR=1: idx = addr >> 2; misaligned if addr[1:0] != 0.
- Errors: out of range if idx >= DEPTH. An error read still returns a response, with rd_err 1 and rd_data 0.
- rd_hold = 1: all read-pipeline registers, including rd_valid, rd_data and rd_err, keep their values. No new request is accepted.
- rd_hold = 0 with no accepted request: rd_valid falls to 0 as the empty slot emerges. rd_data keeps its last value.
- Writes (RUN):
  - wr_en with a legal address writes at the clock edge.
  - wr_en with an illegal address (out of range or misaligned): write dropped, wr_err = 1 for exactly the next cycle.
  - Writes are independent of rd_hold.
- Same-cycle read and write to the same index: read returns old data (read-first). A read accepted in the following cycle returns the new data.
- Reset mid-operation: in-flight responses are discarded, rd_valid = 0 the cycle after rst, and the init sweep restarts from word 0. This overwrites any loaded program.
- Truncation: INIT_BASE + cnt*INIT_STEP is computed in DATA_W bits and wraps modulo 2^DATA_W.

Decomposition:
- Shared package imem_pkg:
  - state encoding: ST_INIT, ST_RUN
  - localparam IDX_W = $clog2(DEPTH)
  - function computing the init word
  - function for address decode, returning idx and the err flag
- One sub-module: imem_rd_pipe, a RD_LAT-stage valid/data/err shift register with a common hold enable.
- The array and FSM stay in the top level.

Test Plan:
- Reset then idle, defaults (RD_LAT=1): busy stays 1 for 128 cycles, then init_done=1 → reads of idx 0, 5, 127 return 0x0, 0x5, 0x7F one cycle after grant.
- Back-to-back reads with RD_LAT=2: idx 1, 2, 3 on consecutive cycles → rd_valid high for 3 consecutive cycles starting 2 cycles after the first grant, data 1, 2, 3 in order.
- Write 0xDEADBEEF to idx 10, reading idx 10 in the same cycle → old value 0xA returned. A read of idx 10 on the next cycle returns 0xDEADBEEF.
- Errors with BYTE_ADDR=1: read addr 0x6 → rd_err=1, rd_data=0. Read addr 0x200 (idx 128) → rd_err=1. Write addr 0x201 → wr_err pulses 1 cycle and memory is unchanged.
- Hold: assert rd_hold for 3 cycles while a response is valid → rd_valid, rd_data and rd_err are frozen, rd_gnt=0 even with rd_req=1. The response resumes after release with no loss or duplication.
- Reset mid-stream: assert rst with 2 reads in flight → rd_valid=0 next cycle, busy=1, and a previously written idx 10 reads 0xA after init_done.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Desc     : Shared FSM encoding, init-pattern and address-decode helpers for
//            the instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Decoded word index plus illegal-address flag (out of range or misaligned).
    typedef struct packed {
        logic [63:0] idx;
        logic        err;
    } addr_dec_t;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // Computed in 64 bits; callers truncate to the word width, which yields
    // the required modulo-2^DATA_W wrap.
    function automatic logic [63:0] init_word(
        input logic [63:0] base,
        input logic [63:0] step,
        input logic [63:0] cnt
    );
        return base + (cnt * step);
    endfunction

    function automatic addr_dec_t addr_decode(
        input logic [63:0] addr,
        input logic        byte_addr,
        input logic [63:0] depth
    );
        addr_dec_t d;
        d.idx = byte_addr ? (addr >> 2) : addr;
        d.err = (d.idx >= depth) || (byte_addr && (addr[1:0] != 2'b00));
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imem_rd_pipe
// Desc     : RD_LAT-stage valid/data/err shift register with common hold.
// Revision : 1.0 - initial release
// ============================================================================
module imem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic              w_valid [RD_LAT+1];
    logic [DATA_W-1:0] w_data  [RD_LAT+1];
    logic              w_err   [RD_LAT+1];

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_err[0]   = in_err;

    for (genvar i = 0; i < RD_LAT; i++) begin : g_stage
        logic              r_valid;
        logic [DATA_W-1:0] r_data;
        logic              r_err;

        // Payload only advances with a valid beat, so an empty slot leaves
        // the last data/err visible downstream.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_err   <= 1'b0;
            end else if (!hold) begin
                r_valid <= w_valid[i];
                if (w_valid[i]) begin
                    r_data <= w_data[i];
                    r_err  <= w_err[i];
                end
            end
        end

        assign w_valid[i+1] = r_valid;
        assign w_data[i+1]  = r_data;
        assign w_err[i+1]   = r_err;
    end

    assign out_valid = w_valid[RD_LAT];
    assign out_data  = w_data[RD_LAT];
    assign out_err   = w_err[RD_LAT];

endmodule
`default_nettype wire

// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pipe
// Desc     : IF-stage instruction memory: pipelined read port, program-load
//            write port and post-reset pattern-fill sweep.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_pipe
    import imem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 128,
    parameter int                ADDR_W    = 32,
    parameter int                BYTE_ADDR = 0,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] INIT_BASE = '0,
    parameter logic [DATA_W-1:0] INIT_STEP = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_hold,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic              busy,
    output logic              init_done
);

    localparam int c_IDX_W = idx_width(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_init_cnt;
    logic               r_busy;
    logic               r_init_done;
    logic               r_wr_err;

    addr_dec_t          w_rd_dec;
    addr_dec_t          w_wr_dec;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [DATA_W-1:0]  w_init_word;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_run;
    logic               w_wr_ok;

    assign w_rd_dec = addr_decode(64'(rd_addr), BYTE_ADDR != 0, 64'(DEPTH));
    assign w_wr_dec = addr_decode(64'(wr_addr), BYTE_ADDR != 0, 64'(DEPTH));
    assign w_rd_idx = c_IDX_W'(w_rd_dec.idx);
    assign w_wr_idx = c_IDX_W'(w_wr_dec.idx);

    assign w_run   = (r_state == ST_RUN);
    assign rd_gnt  = w_run & rd_req & ~rd_hold;
    assign w_wr_ok = w_run & wr_en & ~w_wr_dec.err;

    assign w_init_word = DATA_W'(init_word(64'(INIT_BASE), 64'(INIT_STEP), 64'(r_init_cnt)));

    // Array is read before the edge that performs a write, giving read-first
    // behaviour on a same-cycle collision.
    assign w_rd_word = w_rd_dec.err ? '0 : r_mem[w_rd_idx];

    // Memory contents survive reset; only the sweep rewrites them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_init_cnt] <= w_init_word;
            end else if (w_wr_ok) begin
                r_mem[w_wr_idx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= w_run & wr_en & w_wr_dec.err;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + c_IDX_W'(1);
                if (r_init_cnt == c_IDX_W'(DEPTH - 1)) begin
                    r_state     <= ST_RUN;
                    r_busy      <= 1'b0;
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    imem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .hold      (rd_hold),
        .in_valid  (rd_gnt),
        .in_data   (w_rd_word),
        .in_err    (w_rd_dec.err),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .out_err   (rd_err)
    );

    assign wr_err    = r_wr_err;
    assign busy      = r_busy;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_pipe
// Desc     : Scoreboard bench: word-addressed RD_LAT=1 instance and a
//            byte-addressed RD_LAT=2 instance with a wrapping init pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_pipe;

    localparam int          c_DW     = 32;
    localparam int          c_AW     = 32;
    localparam int          c_DEPTH  = 128;
    localparam logic [31:0] c_B_BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] c_B_STEP = 32'd2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          nh;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rd_req    [2];
    logic [c_AW-1:0] rd_addr   [2];
    logic            rd_hold   [2];
    logic            rd_gnt    [2];
    logic            rd_valid  [2];
    logic [c_DW-1:0] rd_data   [2];
    logic            rd_err    [2];
    logic            wr_en     [2];
    logic [c_AW-1:0] wr_addr   [2];
    logic [c_DW-1:0] wr_data   [2];
    logic            wr_err    [2];
    logic            busy      [2];
    logic            init_done [2];

    logic        ph [2] = '{1'b0, 1'b0};
    int          nh [2] = '{0, 0};
    logic [31:0] mdl [2][c_DEPTH];
    exp_t        sb0 [$];
    exp_t        sb1 [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    instr_mem_pipe #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(32), .BYTE_ADDR(0), .RD_LAT(1),
        .INIT_BASE(32'd0), .INIT_STEP(32'd1)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_hold(rd_hold[0]), .rd_gnt(rd_gnt[0]),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_err(rd_err[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_err(wr_err[0]),
        .busy(busy[0]), .init_done(init_done[0])
    );

    instr_mem_pipe #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(32), .BYTE_ADDR(1), .RD_LAT(2),
        .INIT_BASE(c_B_BASE), .INIT_STEP(c_B_STEP)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_hold(rd_hold[1]), .rd_gnt(rd_gnt[1]),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_err(rd_err[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_err(wr_err[1]),
        .busy(busy[1]), .init_done(init_done[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int d, input int i);
        logic [31:0] ui;
        ui = 32'(i);
        return (d == 0) ? ui : (c_B_BASE + ui * c_B_STEP);
    endfunction

    task automatic decode(input int d, input logic [31:0] a, output int idx, output logic err);
        logic [31:0] w;
        w   = (d == 1) ? (a >> 2) : a;
        err = (w >= 32'(c_DEPTH)) || ((d == 1) && (a[1:0] != 2'b00));
        idx = int'(w[6:0]);
    endtask

    function automatic void sb_push(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic exp_t sb_pop(input int d);
        if (d == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rd_req[d] = 1'b0;
            wr_en[d]  = 1'b0;
        end
    endtask

    task automatic rd(input int d, input logic [31:0] a);
        exp_t e;
        int   idx;
        logic err;
        rd_req[d]  = 1'b1;
        rd_addr[d] = a;
        #1;
        chk($sformatf("d%0d rd_gnt addr=0x%0h", d, a), rd_gnt[d], 1'b1);
        decode(d, a, idx, err);
        e.data = err ? 32'd0 : mdl[d][idx];
        e.err  = err;
        e.nh   = nh[d] + ((d == 0) ? 1 : 2);
        sb_push(d, e);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
        int   idx;
        logic err;
        wr_en[d]   = 1'b1;
        wr_addr[d] = a;
        wr_data[d] = v;
        decode(d, a, idx, err);
        if (!err) mdl[d][idx] = v;
    endtask

    task automatic wait_init(input logic poke);
        int c0 = 0;
        int c1 = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!busy[0] && !busy[1]) break;
            if (busy[0]) c0++;
            if (busy[1]) c1++;
            if (poke && c0 == 100) begin
                rd_req[0]  = 1'b1;
                rd_addr[0] = 32'd0;
                wr_en[0]   = 1'b1;
                wr_addr[0] = 32'd3;
                wr_data[0] = 32'hBAD0_BAD0;
                #1;
                chk("d0 rd_gnt during init", rd_gnt[0], 1'b0);
            end
            if (poke && c0 == 101) begin
                chk("d0 wr_err during init", wr_err[0], 1'b0);
                rd_req[0] = 1'b0;
                wr_en[0]  = 1'b0;
            end
        end
        chk("d0 init busy cycles", 64'(c0), 64'd128);
        chk("d1 init busy cycles", 64'(c1), 64'd128);
        chk("d0 init_done", init_done[0], 1'b1);
        chk("d1 init_done", init_done[1], 1'b1);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < c_DEPTH; i++)
                mdl[d][i] = init_val(d, i);
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ph[d] <= rd_hold[d];
            if (!rd_hold[d]) nh[d] <= nh[d] + 1;
        end
    end

    // A response is new only if the output stage was allowed to advance.
    always @(negedge clk) begin : p_mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst && rd_valid[d] && !ph[d]) begin
                if (sb_size(d) == 0) begin
                    chk($sformatf("d%0d unexpected response", d), 64'd1, 64'd0);
                end else begin
                    e = sb_pop(d);
                    chk($sformatf("d%0d rd_data", d), rd_data[d], e.data);
                    chk($sformatf("d%0d rd_err", d), rd_err[d], e.err);
                    chk($sformatf("d%0d latency", d), 64'(nh[d]), 64'(e.nh));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd_req[d]  = 1'b0;
            rd_addr[d] = '0;
            rd_hold[d] = 1'b0;
            wr_en[d]   = 1'b0;
            wr_addr[d] = '0;
            wr_data[d] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset rd_valid", d), rd_valid[d], 1'b0);
            chk($sformatf("d%0d reset rd_data", d), rd_data[d], 32'd0);
            chk($sformatf("d%0d reset rd_err", d), rd_err[d], 1'b0);
            chk($sformatf("d%0d reset wr_err", d), wr_err[d], 1'b0);
            chk($sformatf("d%0d reset busy", d), busy[d], 1'b1);
            chk($sformatf("d%0d reset init_done", d), init_done[d], 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init(1'b1);

        // Word-addressed reads, including one rewritten-during-init candidate
        cyc(); rd(0, 32'd0);
        cyc(); rd(0, 32'd5);
        cyc(); rd(0, 32'd127);
        cyc(); rd(0, 32'd3);
        cyc(); rd(0, 32'd200);
        cyc(); wr(0, 32'd200, 32'h1111_1111);
        cyc(); @(negedge clk); chk("d0 wr_err out-of-range", wr_err[0], 1'b1);
        cyc(); @(negedge clk); chk("d0 wr_err single pulse", wr_err[0], 1'b0);

        // Back-to-back reads, latency 2
        cyc(); rd(1, 32'h4); @(negedge clk); chk("d1 b2b valid c0", rd_valid[1], 1'b0);
        cyc(); rd(1, 32'h8); @(negedge clk); chk("d1 b2b valid c1", rd_valid[1], 1'b0);
        cyc(); rd(1, 32'hC); @(negedge clk); chk("d1 b2b valid c2", rd_valid[1], 1'b1);
        cyc(); @(negedge clk); chk("d1 b2b valid c3", rd_valid[1], 1'b1);
        cyc(); @(negedge clk); chk("d1 b2b valid c4", rd_valid[1], 1'b1);
        cyc(); @(negedge clk); chk("d1 b2b valid c5", rd_valid[1], 1'b0);

        // Read-first collision then read-after-write
        cyc(); rd(0, 32'd10); wr(0, 32'd10, 32'hDEAD_BEEF);
        cyc(); rd(0, 32'd10); @(negedge clk); chk("d0 wr_err legal write", wr_err[0], 1'b0);
        cyc();

        // Byte-address errors and dropped writes
        cyc(); rd(1, 32'h6);
        cyc(); rd(1, 32'h200);
        cyc(); wr(1, 32'h201, 32'h1234_5678);
        cyc(); wr(1, 32'h29, 32'h8765_4321); @(negedge clk); chk("d1 wr_err 0x201", wr_err[1], 1'b1);
        cyc(); wr(1, 32'h2C, 32'hCAFE_F00D); @(negedge clk); chk("d1 wr_err 0x29", wr_err[1], 1'b1);
        cyc(); rd(1, 32'h28); @(negedge clk); chk("d1 wr_err legal 0x2C", wr_err[1], 1'b0);
        cyc(); rd(1, 32'h2C);
        cyc(); cyc();

        // Hold with two responses in flight
        cyc(); rd(1, 32'h50);
        cyc(); rd(1, 32'h54);
        for (int k = 0; k < 3; k++) begin
            cyc();
            rd_hold[1] = 1'b1;
            rd_req[1]  = 1'b1;
            rd_addr[1] = 32'h58;
            #1;
            chk("d1 rd_gnt under hold", rd_gnt[1], 1'b0);
            @(negedge clk);
            chk("d1 held rd_valid", rd_valid[1], 1'b1);
            chk("d1 held rd_data", rd_data[1], mdl[1][20]);
            chk("d1 held rd_err", rd_err[1], 1'b0);
        end
        cyc(); rd_hold[1] = 1'b0;
        @(negedge clk); chk("d1 release data unchanged", rd_data[1], mdl[1][20]);
        cyc(); @(negedge clk); chk("d1 second response data", rd_data[1], mdl[1][21]);
        cyc(); @(negedge clk);
        chk("d1 empty slot rd_valid", rd_valid[1], 1'b0);
        chk("d1 empty slot keeps rd_data", rd_data[1], mdl[1][21]);

        // Reset with reads in flight
        cyc(); rd(0, 32'd1); rd(1, 32'h4);
        cyc(); rd(0, 32'd2); rd(1, 32'h8);
        cyc(); rst = 1'b1; sb0.delete(); sb1.delete();
        cyc(); rst = 1'b0; #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rd_valid after mid reset", d), rd_valid[d], 1'b0);
            chk($sformatf("d%0d busy after mid reset", d), busy[d], 1'b1);
            chk($sformatf("d%0d init_done after mid reset", d), init_done[d], 1'b0);
        end
        wait_init(1'b0);
        cyc(); rd(0, 32'd10);
        cyc(); rd(1, 32'h2C);
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("d0 scoreboard drained", 64'(sb0.size()), 64'd0);
        chk("d1 scoreboard drained", 64'(sb1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
